// File: rtl/result_checker.sv
// result_checker
//   Pops one DUT result and one {mask, expected} word together, compares them
//   under the mask and keeps saturating vector/failure counters plus a sticky
//   failure flag. Every failing vector is written to the log FIFO as
//   {vector index, masked diff}.
//
// Parameters
//   RTF_WIDTH        width of one DUT result word
//   CNT_WIDTH        width of the counters and of the logged vector index
// Ports
//   i_clock          design clock
//   i_reset_n        synchronous active-low reset
//   i_enable         allows a new compare to start
//   i_clear          synchronous clear of counters, sticky flag and FSM
//   i_rfifo_q        result FIFO data, valid the cycle after o_rfifo_rdreq
//   i_rfifo_rdempty  result FIFO empty
//   o_rfifo_rdreq    result FIFO read request
//   i_efifo_q        expected FIFO data {mask, expected}
//   i_efifo_rdempty  expected FIFO empty
//   o_efifo_rdreq    expected FIFO read request (always equals o_rfifo_rdreq)
//   o_lfifo_data     log record {index, diff}
//   o_lfifo_wrreq    log FIFO write request
//   i_lfifo_wrfull   log FIFO full
//   o_vec_count      vectors compared (saturating)
//   o_fail_count     vectors mismatched (saturating)
//   o_any_fail       sticky mismatch flag
//   o_busy           high whenever the FSM is not idle
module result_checker #(
  parameter int unsigned RTF_WIDTH = 24,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                           i_clock,
  input  logic                           i_reset_n,
  input  logic                           i_enable,
  input  logic                           i_clear,
  input  logic [RTF_WIDTH-1:0]           i_rfifo_q,
  input  logic                           i_rfifo_rdempty,
  output logic                           o_rfifo_rdreq,
  input  logic [2*RTF_WIDTH-1:0]         i_efifo_q,
  input  logic                           i_efifo_rdempty,
  output logic                           o_efifo_rdreq,
  output logic [CNT_WIDTH+RTF_WIDTH-1:0] o_lfifo_data,
  output logic                           o_lfifo_wrreq,
  input  logic                           i_lfifo_wrfull,
  output logic [CNT_WIDTH-1:0]           o_vec_count,
  output logic [CNT_WIDTH-1:0]           o_fail_count,
  output logic                           o_any_fail,
  output logic                           o_busy
);

  typedef enum logic [1:0] {StIdle, StCmp, StLog} state_e;

  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  state_e               r_state;
  logic [RTF_WIDTH-1:0] r_diff;
  logic [CNT_WIDTH-1:0] r_index;
  logic [CNT_WIDTH-1:0] r_vec_count;
  logic [CNT_WIDTH-1:0] r_fail_count;
  logic                 r_any_fail;

  logic [RTF_WIDTH-1:0] w_expected;
  logic [RTF_WIDTH-1:0] w_mask;
  logic [RTF_WIDTH-1:0] w_diff;
  logic                 w_mismatch;
  logic                 w_hold;
  logic                 w_pop;
  logic                 w_log_wr;

  assign w_expected = i_efifo_q[RTF_WIDTH-1:0];
  assign w_mask     = i_efifo_q[2*RTF_WIDTH-1:RTF_WIDTH];
  assign w_diff     = (i_rfifo_q ^ w_expected) & w_mask;
  assign w_mismatch = |w_diff;

  // Clear and reset suppress every FIFO handshake in the cycle they are seen.
  assign w_hold   = i_clear | ~i_reset_n;
  // Both FIFOs are popped together or not at all.
  assign w_pop    = (r_state == StIdle) & i_enable & ~i_rfifo_rdempty & ~i_efifo_rdempty
                    & ~w_hold;
  assign w_log_wr = (r_state == StLog) & ~i_lfifo_wrfull & ~w_hold;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n || i_clear) begin
      r_state      <= StIdle;
      r_diff       <= '0;
      r_index      <= '0;
      r_vec_count  <= '0;
      r_fail_count <= '0;
      r_any_fail   <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_pop) r_state <= StCmp;
        end
        StCmp: begin
          r_diff  <= w_diff;
          // Pre-increment count; saturates together with the counter.
          r_index <= r_vec_count;
          if (r_vec_count != CntMax) r_vec_count <= r_vec_count + CNT_WIDTH'(1);
          if (w_mismatch) begin
            if (r_fail_count != CntMax) r_fail_count <= r_fail_count + CNT_WIDTH'(1);
            r_any_fail <= 1'b1;
            r_state    <= StLog;
          end else begin
            r_state <= StIdle;
          end
        end
        StLog: begin
          if (w_log_wr) r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_rfifo_rdreq = w_pop;
  assign o_efifo_rdreq = w_pop;
  assign o_lfifo_wrreq = w_log_wr;
  assign o_lfifo_data  = {r_index, r_diff};
  assign o_vec_count   = r_vec_count;
  assign o_fail_count  = r_fail_count;
  assign o_any_fail    = r_any_fail;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: doc/result_checker.md
# result_checker

Checker stage directly downstream of the DUT interface. It pops captured DUT responses from the result FIFO and expected-value/mask words from the expected FIFO, compares each pair under the mask, and keeps vector and failure counters. Each failing vector goes to a log FIFO as {index, diff} for the host to read back.

## Interface
- RTF_WIDTH, 24, width of one DUT result word
- CNT_WIDTH, 16, width of the vector/fail counters and of the logged vector index
- clock  in  1  single design clock
- reset_n  in  1  synchronous, active-low reset (sampled on rising edge of clock)
- enable  in  1  level; checker may start a new compare only while high
- clear  in  1  synchronous clear of counters, sticky flag and FSM
- rfifo_q  in  RTF_WIDTH  result FIFO read data, valid the cycle after rfifo_rdreq
- rfifo_rdempty  in  1  result FIFO empty
- rfifo_rdreq  out  1  result FIFO read request
- efifo_q  in  2*RTF_WIDTH  expected FIFO read data: [2*RTF_WIDTH-1:RTF_WIDTH] = mask, [RTF_WIDTH-1:0] = expected; valid the cycle after efifo_rdreq
- efifo_rdempty  in  1  expected FIFO empty
- efifo_rdreq  out  1  expected FIFO read request
- lfifo_data  out  CNT_WIDTH+RTF_WIDTH  log record {index, diff}
- lfifo_wrreq  out  1  log FIFO write request
- lfifo_wrfull  in  1  log FIFO full
- vec_count  out  CNT_WIDTH  vectors compared, saturating
- fail_count  out  CNT_WIDTH  vectors mismatched, saturating
- any_fail  out  1  sticky: at least one mismatch since reset/clear
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, CMP, LOG.
- IDLE: rfifo_rdreq = efifo_rdreq = enable & ~rfifo_rdempty & ~efifo_rdempty & ~clear. These are combinational and always equal. When asserted, go to CMP. Otherwise stay.
- CMP: rfifo_q and efifo_q are valid.
  - diff = (rfifo_q ^ expected) & mask. Mismatch = |diff.
  - Register diff, and register index = vec_count (pre-increment value).
  - vec_count increments. fail_count increments and any_fail sets if mismatch.
  - Next state: LOG if mismatch, else IDLE.
- LOG: lfifo_data = {index, diff_r}. lfifo_wrreq = ~lfifo_wrfull. Go to IDLE in the cycle lfifo_wrreq is high. Stay in LOG while full; no new pops occur.
- Mask bit 0 means don't-care: that bit never causes a mismatch. Mask all-zero always passes.
- Counters saturate at 2^CNT_WIDTH-1 and do not wrap. The logged index also saturates at that value.
- enable dropping only blocks new pops; a compare already in CMP/LOG completes.
- clear (any state): state→IDLE, counters→0, any_fail→0, no rdreq/wrreq that cycle. A popped-but-unlogged vector is discarded. clear has priority over all other updates.
- Never pop only one FIFO: both are read together or not at all.

## Timing
- Reset values: rfifo_rdreq=0, efifo_rdreq=0, lfifo_wrreq=0, lfifo_data=0, vec_count=0, fail_count=0, any_fail=0, busy=0, state=IDLE.
- Counting cycles from the pop cycle T (rdreq high):
  - counters update at the edge ending cycle T+1;
  - vec_count/fail_count visible from T+2;
  - on mismatch with log not full, lfifo_wrreq is high in T+2.
- Throughput: passing vector = 2 cycles/vector; failing vector = 3 cycles plus the number of lfifo_wrfull cycles.
- busy is registered state decode: high T+1 through end of LOG.
- reset_n low mid-operation behaves identically to clear and returns to reset values on the next edge.

## Test plan
- Pass stream: 4 pairs result=0xA5A5A5, exp=0xA5A5A5, mask=0xFFFFFF, enable high → vec_count=4, fail_count=0, any_fail=0, no lfifo_wrreq, rdreq pulses every 2 cycles.
- Masked mismatch: result=0x0000FF, exp=0x000000, mask=0xFFFF00 → pass. Then mask=0xFFFFFF → fail, log record {index=1, diff=0x0000FF}, fail_count=1, any_fail=1.
- Log back-pressure: fail vector with lfifo_wrfull held high 5 cycles → FSM holds in LOG, no rdreq during stall, one wrreq on the first non-full cycle, record unchanged.
- Empty handling: rfifo non-empty, efifo empty for 10 cycles → no rdreq on either FIFO, busy=0. Then efifo fills → single joint pop.
- Saturation: CNT_WIDTH=4, 20 failing vectors → vec_count=fail_count=15, last records carry index=15.
- clear while in LOG with lfifo_wrfull high → next cycle state IDLE, counters 0, any_fail 0, record never written; reset_n pulse low mid-CMP → same result.
